mem_port_arbiter: RTL and testbench

//  Shares the single-port unified instruction/data memory between the IF stage (fetch) and the
//  MEM stage (load/store) of the 5-stage pipelined core. Fixed-latency, one outstanding access.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (IF) and load/store (MEM).
// Load/store wins by default; a starvation counter forces a fetch grant.
module mem_port_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int MEM_LAT    = 2,
   parameter int MAX_STARVE = 4
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_if_req,
   input  logic [AW-1:0]   i_if_addr,
   output logic            o_if_gnt,
   output logic            o_if_rvalid,
   output logic [DW-1:0]   o_if_rdata,
   input  logic            i_ls_req,
   input  logic            i_ls_we,
   input  logic [DW/8-1:0] i_ls_be,
   input  logic [AW-1:0]   i_ls_addr,
   input  logic [DW-1:0]   i_ls_wdata,
   output logic            o_ls_gnt,
   output logic            o_ls_rvalid,
   output logic [DW-1:0]   o_ls_rdata,
   output logic            o_mem_req,
   output logic            o_mem_we,
   output logic [DW/8-1:0] o_mem_be,
   output logic [AW-1:0]   o_mem_addr,
   output logic [DW-1:0]   o_mem_wdata,
   input  logic [DW-1:0]   i_mem_rdata,
   output logic            o_stall_if,
   output logic            o_stall_ls
);

   localparam int BW  = DW / 8;
   localparam int SCW = $clog2(MAX_STARVE + 1);
   localparam logic [3:0]     LAT  = 4'(MEM_LAT);
   localparam logic [SCW-1:0] SMAX = SCW'(MAX_STARVE);

   typedef enum logic {IDLE, WAIT} state_t;
   typedef enum logic {OWN_IF, OWN_LS} owner_t;

   state_t         state_q, state_d;
   owner_t         owner_q, owner_d;
   logic           wr_q, wr_d;
   logic [3:0]     lat_q, lat_d;
   logic [SCW-1:0] starve_q, starve_d;
   logic           live_q;

   logic en, done, window, if_prio, ls_win, if_win;

   // live_q masks the cycle right after reset so all outputs stay low
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q  <= IDLE;
         owner_q  <= OWN_IF;
         wr_q     <= 1'b0;
         lat_q    <= 4'd0;
         starve_q <= '0;
         live_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         wr_q     <= wr_d;
         lat_q    <= lat_d;
         starve_q <= starve_d;
         live_q   <= 1'b1;
      end
   end

   always_comb begin
      en      = i_rst & live_q;
      done    = en & (state_q == WAIT) & (lat_q == LAT);
      window  = en & ((state_q == IDLE) | done);
      if_prio = i_if_req & (starve_q == SMAX);
      ls_win  = window & i_ls_req & ~if_prio;
      if_win  = window & i_if_req & ~ls_win;
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      wr_d     = wr_q;
      lat_d    = lat_q;
      starve_d = starve_q;
      if (ls_win | if_win) begin
         state_d = WAIT;
         owner_d = ls_win ? OWN_LS : OWN_IF;
         wr_d    = ls_win & i_ls_we;
         lat_d   = 4'd1;
      end else if (state_q == WAIT) begin
         if (lat_q == LAT) begin
            state_d = IDLE;
            lat_d   = 4'd0;
         end else begin
            lat_d = lat_q + 4'd1;
         end
      end
      if (!i_if_req || if_win)
         starve_d = '0;
      else if (starve_q != SMAX)
         starve_d = starve_q + SCW'(1);
   end

   always_comb begin
      o_if_gnt    = if_win;
      o_ls_gnt    = ls_win;
      o_mem_req   = ls_win | if_win;
      o_mem_we    = 1'b0;
      o_mem_be    = '0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      unique case (1'b1)
         ls_win: begin
            o_mem_we    = i_ls_we;
            o_mem_be    = i_ls_we ? i_ls_be : {BW{1'b1}};
            o_mem_addr  = i_ls_addr;
            o_mem_wdata = i_ls_we ? i_ls_wdata : '0;
         end
         if_win: begin
            o_mem_be   = {BW{1'b1}};
            o_mem_addr = i_if_addr;
         end
         default: ;
      endcase
   end

   always_comb begin
      o_if_rvalid = done & (owner_q == OWN_IF);
      o_ls_rvalid = done & (owner_q == OWN_LS);
      o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
      o_ls_rdata  = (o_ls_rvalid & ~wr_q) ? i_mem_rdata : '0;
      o_stall_if  = en & ((i_if_req & ~if_win) |
                    ((state_q == WAIT) & (owner_q == OWN_IF) & ~o_if_rvalid));
      o_stall_ls  = en & ((i_ls_req & ~ls_win) |
                    ((state_q == WAIT) & (owner_q == OWN_LS) & ~o_ls_rvalid));
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance plus a
// MEM_LAT=1 instance for back-to-back throughput.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   int          checks = 0;
   int          errors = 0;

   logic        if_req, ls_req, ls_we;
   logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
   logic [3:0]  ls_be;
   logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid;
   logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
   logic        mem_req, mem_we, stall_if, stall_ls;
   logic [3:0]  mem_be;
   logic [31:0] a1, a2;

   logic        b_if_req, b_ls_req;
   logic [31:0] b_if_addr, b_ls_addr, b_mem_rdata;
   logic        b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid;
   logic [31:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata;
   logic        b_mem_req, b_mem_we, b_stall_if, b_stall_ls;
   logic [3:0]  b_mem_be;
   logic [31:0] b_a1;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .MAX_STARVE(4)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_if_req(if_req), .i_if_addr(if_addr),
      .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
      .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_be(ls_be),
      .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
      .o_ls_gnt(ls_gnt), .o_ls_rvalid(ls_rvalid), .o_ls_rdata(ls_rdata),
      .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_be(mem_be),
      .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata),
      .o_stall_if(stall_if), .o_stall_ls(stall_ls)
   );

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .MAX_STARVE(4)) dut1 (
      .i_clk(clk), .i_rst(rst),
      .i_if_req(b_if_req), .i_if_addr(b_if_addr),
      .o_if_gnt(b_if_gnt), .o_if_rvalid(b_if_rvalid), .o_if_rdata(b_if_rdata),
      .i_ls_req(b_ls_req), .i_ls_we(1'b0), .i_ls_be(4'h0),
      .i_ls_addr(b_ls_addr), .i_ls_wdata(32'h0),
      .o_ls_gnt(b_ls_gnt), .o_ls_rvalid(b_ls_rvalid), .o_ls_rdata(b_ls_rdata),
      .o_mem_req(b_mem_req), .o_mem_we(b_mem_we), .o_mem_be(b_mem_be),
      .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata),
      .i_mem_rdata(b_mem_rdata),
      .o_stall_if(b_stall_if), .o_stall_ls(b_stall_ls)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // fixed-latency memory models keyed on the presented address
   always @(posedge clk) begin
      a1   <= mem_addr;
      a2   <= a1;
      b_a1 <= b_mem_addr;
   end
   assign mem_rdata   = memfn(a2);
   assign b_mem_rdata = memfn(b_a1);

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_if(input logic r, input logic [31:0] a);
      if_req  = r;
      if_addr = a;
   endtask

   task automatic set_ls(input logic r, input logic w, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] d);
      ls_req   = r;
      ls_we    = w;
      ls_be    = be;
      ls_addr  = a;
      ls_wdata = d;
   endtask

   initial begin
      rst = 1'b0;
      set_if(0, 0);
      set_ls(0, 0, 0, 0, 0);
      b_if_req = 0; b_if_addr = 0;
      b_ls_req = 0; b_ls_addr = 0;

      // reset cycle and the masked cycle after it
      tick();
      set_if(1, 32'h0);
      #1;
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_stall_if", stall_if, 0);
      tick();
      rst = 1'b1;
      #1;
      chk("post_rst_if_gnt", if_gnt, 0);
      chk("post_rst_stall_if", stall_if, 0);

      // fetch only, 0x0 then 0x4
      tick();
      #1;
      chk("f0_gnt", if_gnt, 1);
      chk("f0_addr", mem_addr, 32'h0);
      chk("f0_be", mem_be, 4'hF);
      chk("f0_we", mem_we, 0);
      chk("f0_stall", stall_if, 0);
      tick();
      set_if(1, 32'h4);
      #1;
      chk("f1_gnt", if_gnt, 0);
      chk("f1_stall", stall_if, 1);
      chk("f1_rdata0", if_rdata, 32'h0);
      tick();
      #1;
      chk("f2_rvalid", if_rvalid, 1);
      chk("f2_rdata", if_rdata, memfn(32'h0));
      chk("f2_gnt", if_gnt, 1);
      chk("f2_addr", mem_addr, 32'h4);
      chk("f2_stall", stall_if, 0);
      tick();
      set_if(0, 0);
      #1;
      chk("f3_stall", stall_if, 1);
      tick();
      #1;
      chk("f4_rvalid", if_rvalid, 1);
      chk("f4_rdata", if_rdata, memfn(32'h4));
      chk("f4_stall", stall_if, 0);

      // simultaneous fetch and load: load first
      tick();
      set_if(1, 32'h10);
      set_ls(1, 0, 4'hF, 32'h100, 0);
      #1;
      chk("u0_ls_gnt", ls_gnt, 1);
      chk("u0_if_gnt", if_gnt, 0);
      chk("u0_addr", mem_addr, 32'h100);
      chk("u0_stall_if", stall_if, 1);
      chk("u0_stall_ls", stall_ls, 0);
      tick();
      set_ls(0, 0, 0, 0, 0);
      #1;
      chk("u1_stall_ls", stall_ls, 1);
      chk("u1_if_gnt", if_gnt, 0);
      tick();
      #1;
      chk("u2_ls_rvalid", ls_rvalid, 1);
      chk("u2_ls_rdata", ls_rdata, memfn(32'h100));
      chk("u2_if_gnt", if_gnt, 1);
      chk("u2_addr", mem_addr, 32'h10);
      chk("u2_if_rvalid", if_rvalid, 0);
      tick();
      set_if(0, 0);
      tick();
      #1;
      chk("u4_if_rvalid", if_rvalid, 1);
      chk("u4_if_rdata", if_rdata, memfn(32'h10));
      chk("u4_ls_rvalid", ls_rvalid, 0);

      // store full word, then store with no byte enables
      tick();
      set_ls(1, 1, 4'hF, 32'h200, 32'hDEADBEEF);
      #1;
      chk("s0_gnt", ls_gnt, 1);
      chk("s0_we", mem_we, 1);
      chk("s0_wdata", mem_wdata, 32'hDEADBEEF);
      chk("s0_be", mem_be, 4'hF);
      chk("s0_addr", mem_addr, 32'h200);
      tick();
      set_ls(0, 0, 0, 0, 0);
      #1;
      chk("s1_rvalid", ls_rvalid, 0);
      tick();
      #1;
      chk("s2_rvalid", ls_rvalid, 1);
      chk("s2_rdata", ls_rdata, 32'h0);
      tick();
      set_ls(1, 1, 4'h0, 32'h204, 32'h1234_5678);
      #1;
      chk("z0_gnt", mem_req, 1);
      chk("z0_be", mem_be, 4'h0);
      tick();
      set_ls(0, 0, 0, 0, 0);
      tick();
      #1;
      chk("z2_rvalid", ls_rvalid, 1);
      chk("z2_rdata", ls_rdata, 32'h0);

      // loads every window while fetch is held: starvation override
      tick();
      set_if(1, 32'h20);
      set_ls(1, 0, 4'hF, 32'h300, 0);
      #1;
      chk("st0_ls_gnt", ls_gnt, 1);
      tick();
      set_ls(1, 0, 4'hF, 32'h304, 0);
      #1;
      chk("st1_if_gnt", if_gnt, 0);
      tick();
      #1;
      chk("st2_ls_gnt", ls_gnt, 1);
      chk("st2_if_gnt", if_gnt, 0);
      chk("st2_rdata", ls_rdata, memfn(32'h300));
      tick();
      set_ls(1, 0, 4'hF, 32'h308, 0);
      tick();
      #1;
      chk("st4_if_gnt", if_gnt, 1);
      chk("st4_ls_gnt", ls_gnt, 0);
      chk("st4_addr", mem_addr, 32'h20);
      chk("st4_ls_rdata", ls_rdata, memfn(32'h304));
      chk("st4_stall_ls", stall_ls, 1);
      tick();
      set_if(0, 0);
      tick();
      #1;
      chk("st6_if_rdata", if_rdata, memfn(32'h20));
      chk("st6_ls_gnt", ls_gnt, 1);
      tick();
      set_ls(0, 0, 0, 0, 0);
      tick();
      #1;
      chk("st8_ls_rdata", ls_rdata, memfn(32'h308));

      // reset in the middle of a load
      tick();
      set_ls(1, 0, 4'hF, 32'h400, 0);
      #1;
      chk("r0_ls_gnt", ls_gnt, 1);
      tick();
      rst = 1'b0;
      set_ls(0, 0, 0, 0, 0);
      #1;
      chk("r1_outs_zero", |{if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid,
                            ls_rdata, mem_req, mem_we, mem_be, mem_addr,
                            mem_wdata, stall_if, stall_ls}, 0);
      tick();
      rst = 1'b1;
      set_if(1, 32'h40);
      #1;
      chk("r2_ls_rvalid", ls_rvalid, 0);
      chk("r2_if_gnt", if_gnt, 0);
      tick();
      #1;
      chk("r3_if_gnt", if_gnt, 1);
      chk("r3_addr", mem_addr, 32'h40);
      tick();
      set_if(0, 0);
      #1;
      chk("r4_ls_rvalid", ls_rvalid, 0);
      tick();
      #1;
      chk("r5_if_rdata", if_rdata, memfn(32'h40));

      // MEM_LAT=1: alternating load/fetch, one grant and one rvalid per cycle
      for (int k = 0; k < 6; k++) begin
         tick();
         b_ls_req  = (k % 2 == 0);
         b_if_req  = (k % 2 == 1);
         b_ls_addr = 32'h500 + 32'(4 * k);
         b_if_addr = 32'h600 + 32'(4 * k);
         #1;
         chk("b_mem_req", b_mem_req, 1);
         chk("b_gnt", {b_ls_gnt, b_if_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
         chk("b_we_be", {b_mem_we, b_mem_be, b_mem_wdata}, {1'b0, 4'hF, 32'h0});
         chk("b_stall", {b_stall_if, b_stall_ls}, 0);
         if (k > 0) begin
            if (k % 2 == 1) begin
               chk("b_ls_rvalid", b_ls_rvalid, 1);
               chk("b_ls_rdata", b_ls_rdata, memfn(32'h500 + 32'(4 * (k - 1))));
            end else begin
               chk("b_if_rvalid", b_if_rvalid, 1);
               chk("b_if_rdata", b_if_rdata, memfn(32'h600 + 32'(4 * (k - 1))));
            end
         end
      end
      tick();
      b_ls_req = 0;
      b_if_req = 0;
      #1;
      chk("b_last_rvalid", b_if_rvalid, 1);
      chk("b_last_rdata", b_if_rdata, memfn(32'h614));
      chk("b_last_req", b_mem_req, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
